axi_master: RTL and testbench

AXI_MASTER -- requirements
Module: axi_master

---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: master FSM states, burst/response encodings and
// the fixed cache/prot attributes driven on every request.
package axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_RSP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

  localparam int unsigned BOUNDARY_BYTES = 4096;

  // Worst-case merge of two AXI responses (higher encoding is worse).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_master.sv
// Single-outstanding AXI4 master: converts a command plus simple data streams
// into INCR bursts and reports one completion pulse per command.
module axi_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  // write data stream
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read data stream
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [1:0]            rsp_resp,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4 read data
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  write_q, write_d;
  logic [1:0]            resp_q, resp_d;
  logic                  perr_q, perr_d;

  logic        run;
  logic        in_idle, in_aw, in_w, in_b, in_ar, in_r, in_rsp;
  logic [31:0] end_off;
  logic        crosses_4k;

  // Burst end offset within its 4 KB page; anything past the page is refused.
  assign end_off    = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH));
  assign crosses_4k = end_off > BOUNDARY_BYTES;

  assign run     = !rst;
  assign in_idle = run && (state_q == S_IDLE);
  assign in_aw   = run && (state_q == S_AW);
  assign in_w    = run && (state_q == S_W);
  assign in_b    = run && (state_q == S_B);
  assign in_ar   = run && (state_q == S_AR);
  assign in_r    = run && (state_q == S_R);
  assign in_rsp  = run && (state_q == S_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      write_q <= 1'b0;
      resp_q  <= RESP_OKAY;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    write_d = write_q;
    resp_d  = resp_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        cnt_d   = cmd_len;
        id_d    = cmd_id;
        write_d = cmd_write;
        resp_d  = RESP_OKAY;
        perr_d  = 1'b0;
        if (crosses_4k) begin
          resp_d  = RESP_SLVERR;
          state_d = S_RSP;
        end else begin
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: if (m_axi_wvalid && m_axi_wready) begin
        if (cnt_q == 8'd0) state_d = S_B;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_B: if (m_axi_bvalid) begin
        resp_d  = m_axi_bresp;
        state_d = S_RSP;
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: if (m_axi_rvalid && m_axi_rready) begin
        resp_d = resp_worst(resp_q, m_axi_rresp);
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        // A beat-count/rlast disagreement overrides whatever the slave reported.
        if (m_axi_rlast) begin
          state_d = S_RSP;
          if (cnt_q != 8'd0 || perr_q) resp_d = RESP_SLVERR;
        end else if (cnt_q == 8'd0) begin
          perr_d = 1'b1;
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command / stream side
  assign cmd_ready = in_idle;
  assign wr_ready  = in_w && m_axi_wready;
  assign rd_data   = in_r ? m_axi_rdata : '0;
  assign rd_last   = in_r && m_axi_rlast;
  assign rd_valid  = in_r && m_axi_rvalid;
  assign rsp_valid = in_rsp;
  assign rsp_write = write_q;
  assign rsp_id    = id_q;
  assign rsp_resp  = resp_q;

  // Write address: fields come straight from the latched command registers.
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = run ? AXSIZE : 3'd0;
  assign m_axi_awburst = run ? BURST_INCR : 2'b00;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = run ? CACHE_DEFAULT : 4'd0;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = in_aw;

  assign m_axi_wdata   = in_w ? wr_data : '0;
  assign m_axi_wstrb   = in_w ? wr_strb : '0;
  assign m_axi_wlast   = in_w && (cnt_q == 8'd0);
  assign m_axi_wvalid  = in_w && wr_valid;

  assign m_axi_bready  = in_b;

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = run ? AXSIZE : 3'd0;
  assign m_axi_arburst = run ? BURST_INCR : 2'b00;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = run ? CACHE_DEFAULT : 4'd0;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = in_ar;

  assign m_axi_rready  = in_r && rd_ready;

  // IDs are not checked: only one transaction is ever in flight.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

endmodule

// File: tb/tb_axi_master.sv
`timescale 1ns/1ps
module tb_axi_master;

  localparam int DW = 32, AW = 16, SW = 4, IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '1;
  logic          wr_valid = 0, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready = 1;
  logic          rsp_valid, rsp_write;
  logic [IW-1:0] rsp_id;
  logic [1:0]    rsp_resp;

  logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int          aw_delay = 0, err_beat = -1, aw_wait = 0;
  logic [31:0] mem [0:1023];
  logic [9:0]  w_ptr = '0, r_ptr = '0;
  logic [7:0]  r_len = '0, r_idx = '0;
  logic        r_active = 0, bvalid_q = 0;

  assign m_axi_awready = (aw_wait >= aw_delay);
  assign m_axi_wready  = 1'b1;
  assign m_axi_bvalid  = bvalid_q;
  assign m_axi_bresp   = 2'b00;
  assign m_axi_bid     = '0;
  assign m_axi_arready = !r_active;
  assign m_axi_rvalid  = r_active;
  assign m_axi_rdata   = mem[r_ptr];
  assign m_axi_rlast   = r_active && (r_idx == r_len);
  assign m_axi_rresp   = (int'(r_idx) == err_beat) ? 2'b10 : 2'b00;
  assign m_axi_rid     = '0;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait  <= 0;
      bvalid_q <= 1'b0;
      r_active <= 1'b0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
      else if (m_axi_awvalid) begin
        aw_wait <= 0;
        w_ptr   <= m_axi_awaddr[11:2];
      end
      if (m_axi_wvalid && m_axi_wready) begin
        for (int b = 0; b < SW; b++)
          if (m_axi_wstrb[b]) mem[w_ptr][8*b +: 8] <= m_axi_wdata[8*b +: 8];
        w_ptr <= w_ptr + 10'd1;
        if (m_axi_wlast) bvalid_q <= 1'b1;
      end
      if (bvalid_q && m_axi_bready) bvalid_q <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        r_active <= 1'b1;
        r_ptr    <= m_axi_araddr[11:2];
        r_len    <= m_axi_arlen;
        r_idx    <= '0;
      end else if (m_axi_rvalid && m_axi_rready) begin
        r_ptr <= r_ptr + 10'd1;
        r_idx <= r_idx + 8'd1;
        if (m_axi_rlast) r_active <= 1'b0;
      end
    end
  end

  int rsp_cnt = 0, w_total = 0, wlast_cnt = 0, wlast_at = 0, rd_total = 0;
  int aw_stall_cnt = 0, aw_unstable = 0, ax_cnt = 0, early_w = 0;
  logic [1:0]    rsp_resp_q = '0;
  logic          rsp_write_q = 0;
  logic [IW-1:0] rsp_id_q = '0;
  logic [31:0]   rd_data_log [0:1023];
  logic          rd_last_log [0:1023];
  logic          aw_prev_stall = 0, aw_done = 0;
  logic [AW-1:0] aw_prev_addr = '0;
  logic [7:0]    aw_prev_len = '0;

  always @(posedge clk) begin
    if (rsp_valid) begin
      rsp_cnt     <= rsp_cnt + 1;
      rsp_resp_q  <= rsp_resp;
      rsp_write_q <= rsp_write;
      rsp_id_q    <= rsp_id;
    end
    if (rd_valid && rd_ready) begin
      rd_data_log[rd_total] <= rd_data;
      rd_last_log[rd_total] <= rd_last;
      rd_total <= rd_total + 1;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_total <= w_total + 1;
      if (m_axi_wlast) begin
        wlast_cnt <= wlast_cnt + 1;
        wlast_at  <= w_total;
      end
    end
    if (m_axi_awvalid && !m_axi_awready) aw_stall_cnt <= aw_stall_cnt + 1;
    if (m_axi_awvalid && aw_prev_stall &&
        (m_axi_awaddr != aw_prev_addr || m_axi_awlen != aw_prev_len)) aw_unstable <= aw_unstable + 1;
    aw_prev_stall <= m_axi_awvalid && !m_axi_awready;
    aw_prev_addr  <= m_axi_awaddr;
    aw_prev_len   <= m_axi_awlen;
    if (m_axi_awvalid || m_axi_arvalid) ax_cnt <= ax_cnt + 1;
    if (m_axi_wvalid && !aw_done) early_w <= early_w + 1;
    if (rst) aw_done <= 1'b0;
    else if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
    else if (m_axi_wvalid && m_axi_wready && m_axi_wlast) aw_done <= 1'b0;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [31:0] wd(input int b, input int k);
    return 32'hA500_0000 | (32'(b) << 12) | 32'(k);
  endfunction

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
    chk("cmd_ready_idle", cmd_ready === 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_wdata(input int n, input int base);
    int k = 0;
    wr_valid = 1'b1; wr_strb = '1; wr_data = wd(base, 0);
    for (int g = 0; g < 1000 && k < n; g++) begin
      @(negedge clk);
      if (wr_ready) begin
        @(posedge clk);
        k++;
        #1 wr_data = wd(base, k);
        if (k == n) wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int base);
    for (int c = 0; c < 2000 && rsp_cnt == base; c++) @(negedge clk);
    chk("rsp_count", rsp_cnt === base + 1);
  endtask

  initial begin
    int rb, wb, lb, sb, xb, base;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready === 1'b0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, rd_valid, wr_ready} === 8'h00);
    chk("rst_awaddr", m_axi_awaddr === 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready === 1'b1);

    base = rsp_cnt; wb = w_total; lb = wlast_cnt;
    issue(1'b1, 16'h0100, 8'd3, 8'h5A);
    send_wdata(4, 1);
    wait_rsp(base);
    chk("wr4_beats", (w_total - wb) === 4);
    chk("wr4_wlast_cnt", (wlast_cnt - lb) === 1);
    chk("wr4_wlast_idx", (wlast_at - wb) === 3);
    chk("wr4_resp", rsp_resp_q === 2'b00);
    chk("wr4_write", rsp_write_q === 1'b1);
    chk("wr4_id", rsp_id_q === 8'h5A);

    base = rsp_cnt; rb = rd_total;
    issue(1'b0, 16'h0100, 8'd3, 8'h21);
    @(negedge clk);
    chk("ar_valid", m_axi_arvalid === 1'b1);
    chk("ar_fields", {m_axi_arid, m_axi_araddr, m_axi_arlen} === {8'h21, 16'h0100, 8'd3});
    chk("ar_attr", {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} === {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
    wait_rsp(base);
    chk("rd4_beats", (rd_total - rb) === 4);
    for (int k = 0; k < 4; k++) begin
      chk("rd4_data", rd_data_log[rb + k] === wd(1, k));
      chk("rd4_last", rd_last_log[rb + k] === (k == 3));
    end
    chk("rd4_resp", rsp_resp_q === 2'b00);
    chk("rd4_write", rsp_write_q === 1'b0);

    wr_valid = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    chk("idle_gating", {wr_ready, m_axi_rready, m_axi_wvalid} === 3'b000);
    wr_valid = 1'b0;

    aw_delay = 10; base = rsp_cnt; wb = w_total; lb = wlast_cnt; sb = aw_stall_cnt;
    issue(1'b1, 16'h0200, 8'd0, 8'h33);
    @(negedge clk);
    chk("aw_fields", {m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen} === {1'b1, 8'h33, 16'h0200, 8'd0});
    chk("aw_attr", {m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot} === {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
    send_wdata(1, 2);
    wait_rsp(base);
    aw_delay = 0;
    chk("aw_stall_cycles", (aw_stall_cnt - sb) === 10);
    chk("len0_beats", (w_total - wb) === 1);
    chk("len0_wlast", (wlast_cnt - lb) === 1);
    chk("len0_resp", rsp_resp_q === 2'b00);

    base = rsp_cnt; xb = ax_cnt;
    issue(1'b1, 16'h0FF0, 8'd3, 8'h44);
    send_wdata(4, 4);
    wait_rsp(base);
    chk("fit4k_addr_phase", (ax_cnt - xb) > 0);
    chk("fit4k_resp", rsp_resp_q === 2'b00);

    base = rsp_cnt; xb = ax_cnt;
    issue(1'b0, 16'h0FF0, 8'd7, 8'h55);
    @(negedge clk);
    chk("x4k_rsp_valid", rsp_valid === 1'b1);
    chk("x4k_rsp_resp", rsp_resp === 2'b10);
    chk("x4k_rsp_id", rsp_id === 8'h55);
    @(negedge clk);
    chk("x4k_rsp_pulse", rsp_valid === 1'b0);
    chk("x4k_no_addr", (ax_cnt - xb) === 0);
    chk("x4k_count", rsp_cnt === base + 1);

    base = rsp_cnt; wb = w_total; lb = wlast_cnt;
    issue(1'b1, 16'h0400, 8'd255, 8'h66);
    send_wdata(256, 5);
    wait_rsp(base);
    chk("len255_beats", (w_total - wb) === 256);
    chk("len255_wlast_cnt", (wlast_cnt - lb) === 1);
    chk("len255_wlast_idx", (wlast_at - wb) === 255);

    err_beat = 1; base = rsp_cnt; rb = rd_total;
    issue(1'b0, 16'h0100, 8'd3, 8'h77);
    for (int c = 0; c < 200 && rsp_cnt == base; c++) begin
      @(negedge clk);
      rd_ready = ~rd_ready;
    end
    rd_ready = 1'b1; err_beat = -1;
    chk("rdtog_done", rsp_cnt === base + 1);
    chk("rdtog_beats", (rd_total - rb) === 4);
    for (int k = 0; k < 4; k++) begin
      chk("rdtog_data", rd_data_log[rb + k] === wd(1, k));
    end
    chk("rdtog_resp", rsp_resp_q === 2'b10);

    base = rsp_cnt;
    issue(1'b1, 16'h0300, 8'd3, 8'h88);
    send_wdata(1, 3);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = wd(3, 1); rst = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, rsp_valid, rd_valid} === 6'b000000);
    chk("midrst_cmd_ready", cmd_ready === 1'b0);
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("midrst_no_rsp", rsp_cnt === base);
    chk("midrst_cmd_ready_back", cmd_ready === 1'b1);
    base = rsp_cnt; rb = rd_total;
    issue(1'b0, 16'h0100, 8'd0, 8'h99);
    wait_rsp(base);
    chk("postrst_rd_data", rd_data_log[rb] === wd(1, 0));
    chk("postrst_resp", rsp_resp_q === 2'b00);
    chk("postrst_id", rsp_id_q === 8'h99);

    chk("aw_stable", aw_unstable === 0);
    chk("no_early_w", early_w === 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
